// File: rtl/goldschmidt_pkg.sv
// Shared types and encodings for the Goldschmidt divide/square-root sequencer.
package goldschmidt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gs_state_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;

  // Operand mux select codes shared by sA and sB
  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;
  localparam logic [1:0] SEL_2 = 2'b10;
  localparam logic [1:0] SEL_3 = 2'b11;

  // Cycle counter width: covers up to 16 divide cycles or 2+3*4 root cycles
  localparam int C_W = 4;

endpackage

// File: rtl/goldschmidt_seq_schedule.sv
// Combinational schedule decode: (op, c, state) -> operand selects and register enables.
module gs_schedule
  import goldschmidt_pkg::*;
#(
  parameter int DIV_LEN    = 12,
  parameter int SQRT_ITERS = 4
) (
  input  logic [1:0]     op,
  input  logic [C_W-1:0] c,
  input  gs_state_t      state,
  output logic [1:0]     sA,
  output logic [1:0]     sB,
  output logic           enableN,
  output logic           enableD,
  output logic           enableK,
  output logic           enableQD
);

  localparam logic [C_W-1:0] DIV_LAST = C_W'(DIV_LEN - 1);
  localparam logic [C_W-1:0] SQ_LAST  = C_W'(2 + 3 * SQRT_ITERS);

  logic           m;
  logic [C_W-1:0] c_m2;
  logic [C_W-1:0] t_full;
  logic [1:0]     t;

  assign m      = (c >= C_W'(2)) && (c < DIV_LAST);
  assign c_m2   = c - C_W'(2);
  assign t_full = c_m2 % C_W'(3);
  assign t      = t_full[1:0];

  always_comb begin
    sA       = SEL_0;
    sB       = SEL_0;
    enableN  = 1'b0;
    enableD  = 1'b0;
    enableK  = 1'b0;
    enableQD = 1'b0;
    if (state == RUN) begin
      if (op == OP_DIV) begin
        sA       = {c == DIV_LAST, m};
        sB       = {m, c[0]};
        enableN  = ~c[0];
        enableD  = c[0];
        enableK  = c[0];
        enableQD = (c == DIV_LAST);
      end else if (c == C_W'(0)) begin
        enableN = 1'b1;
      end else if (c == C_W'(1)) begin
        sB      = SEL_3;
        enableD = 1'b1;
      end else if (c == SQ_LAST) begin
        sA      = SEL_1;
        sB      = SEL_2;
        enableN = 1'b1;
      end else begin
        // Each root iteration is three cycles: update D/K, then N, then D
        case (t)
          2'd0: begin
            sA      = SEL_2;
            sB      = SEL_2;
            enableD = 1'b1;
            enableK = 1'b1;
          end
          2'd1: begin
            sA      = SEL_1;
            sB      = SEL_2;
            enableN = 1'b1;
          end
          default: begin
            sA      = SEL_1;
            sB      = SEL_3;
            enableD = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/goldschmidt_seq.sv
// Goldschmidt divide/square-root control sequencer (IDLE/RUN/DONE).
// Optional abort input enabled by defining GS_SEQ_ABORT_EN.
module goldschmidt_seq
  import goldschmidt_pkg::*;
#(
  parameter int DIV_LEN    = 12,
  parameter int SQRT_ITERS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
`ifdef GS_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] op,
  output logic [1:0] sA,
  output logic [1:0] sB,
  output logic       enableN,
  output logic       enableD,
  output logic       enableK,
  output logic       enableQD,
  output logic       busy
);

  localparam logic [C_W-1:0] DIV_LAST = C_W'(DIV_LEN - 1);
  localparam logic [C_W-1:0] SQ_LAST  = C_W'(2 + 3 * SQRT_ITERS);

  gs_state_t      state;
  logic [C_W-1:0] c;
  logic           last_cycle;
  logic           abort_req;

`ifdef GS_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_cycle = (op == OP_DIV) ? (c == DIV_LAST) : (c == SQ_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      c     <= '0;
      op    <= OP_DIV;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op    <= req_op;
            c     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          c <= c + 1'b1;
          if (abort_req)       state <= IDLE;
          else if (last_cycle) state <= DONE;
        end
        DONE: begin
          // Abort wins over a simultaneous consumer handshake
          if (abort_req || resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state == RUN);

  gs_schedule #(
    .DIV_LEN    (DIV_LEN),
    .SQRT_ITERS (SQRT_ITERS)
  ) u_schedule (
    .op       (op),
    .c        (c),
    .state    (state),
    .sA       (sA),
    .sB       (sB),
    .enableN  (enableN),
    .enableD  (enableD),
    .enableK  (enableK),
    .enableQD (enableQD)
  );

endmodule

// File: tb/tb_goldschmidt_seq.sv
// Directed testbench for goldschmidt_seq at default parameters.
module tb_goldschmidt_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] op;
  logic [1:0] sA;
  logic [1:0] sB;
  logic       enableN;
  logic       enableD;
  logic       enableK;
  logic       enableQD;
  logic       busy;
`ifdef GS_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] div_tab [12];
  logic [7:0] sqrt_tab[15];
  logic [7:0] sched;
  logic [2:0] status;

  assign sched  = {sA, sB, enableN, enableD, enableK, enableQD};
  assign status = {req_ready, resp_valid, busy};

  always #5 clk = ~clk;

  goldschmidt_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
`ifdef GS_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .op         (op),
    .sA         (sA),
    .sB         (sB),
    .enableN    (enableN),
    .enableD    (enableD),
    .enableK    (enableK),
    .enableQD   (enableQD),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] o);
    req_valid = 1'b1;
    req_op    = o;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; resp_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if ({status, op, sched} !== {3'b100, 2'b00, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_hold: got st=%b op=%b sch=%b want st=100 op=00 sch=00000000", status, op, sched);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (status !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release: got st=%b want 100", status);
    end
  endtask

  task automatic test_divide();
    accept(2'b00);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({busy, op, sched} !== {1'b1, 2'b00, div_tab[i]}) begin
        n_bad++;
        $display("FAIL div_c%0d: got busy=%b op=%b sch=%b want busy=1 op=00 sch=%b", i, busy, op, sched, div_tab[i]);
      end
      step();
    end
    n_cmp++;
    if ({status, sched} !== {3'b010, 8'h00}) begin
      n_bad++;
      $display("FAIL div_done: got st=%b sch=%b want st=010 sch=00000000", status, sched);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (status !== 3'b100) begin
      n_bad++;
      $display("FAIL div_idle: got st=%b want 100", status);
    end
  endtask

  task automatic test_sqrt();
    accept(2'b01);
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if ({busy, op, sched} !== {1'b1, 2'b01, sqrt_tab[i]}) begin
        n_bad++;
        $display("FAIL sqrt_c%0d: got busy=%b op=%b sch=%b want busy=1 op=01 sch=%b", i, busy, op, sched, sqrt_tab[i]);
      end
      step();
    end
    n_cmp++;
    if ({status, op, sched} !== {3'b010, 2'b01, 8'h00}) begin
      n_bad++;
      $display("FAIL sqrt_done: got st=%b op=%b sch=%b want st=010 op=01 sch=00000000", status, op, sched);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (status !== 3'b100) begin
      n_bad++;
      $display("FAIL sqrt_idle: got st=%b want 100", status);
    end
  endtask

  task automatic test_backpressure();
    accept(2'b00);
    repeat (12) step();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({status, sched} !== {3'b010, 8'h00}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got st=%b sch=%b want st=010 sch=00000000", k, status, sched);
      end
      step();
    end
    resp_ready = 1'b1;
    n_cmp++;
    if (status !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_handshake: got st=%b want 010", status);
    end
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (status !== 3'b100) begin
      n_bad++;
      $display("FAIL bp_idle: got st=%b want 100", status);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    accept(2'b01);
    repeat (6) step();
    n_cmp++;
    if ({busy, sched} !== {1'b1, sqrt_tab[6]}) begin
      n_bad++;
      $display("FAIL rmid_c6: got busy=%b sch=%b want busy=1 sch=%b", busy, sched, sqrt_tab[6]);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({status, op, sched} !== {3'b100, 2'b00, 8'h00}) begin
      n_bad++;
      $display("FAIL rmid_async: got st=%b op=%b sch=%b want st=100 op=00 sch=00000000", status, op, sched);
    end
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (resp_valid || busy) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_no_resp: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = 2'b00;
    step();
    req_op = 2'b10;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({busy, op, sched} !== {1'b1, 2'b00, div_tab[i]}) begin
        n_bad++;
        $display("FAIL b2b_div_c%0d: got busy=%b op=%b sch=%b want busy=1 op=00 sch=%b", i, busy, op, sched, div_tab[i]);
      end
      step();
    end
    n_cmp++;
    if (status !== 3'b010) begin
      n_bad++;
      $display("FAIL b2b_done1: got st=%b want 010", status);
    end
    step();
    n_cmp++;
    if (status !== 3'b100) begin
      n_bad++;
      $display("FAIL b2b_gap: got st=%b want 100", status);
    end
    step();
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if ({busy, op, sched} !== {1'b1, 2'b10, sqrt_tab[i]}) begin
        n_bad++;
        $display("FAIL b2b_sqrt_c%0d: got busy=%b op=%b sch=%b want busy=1 op=10 sch=%b", i, busy, op, sched, sqrt_tab[i]);
      end
      step();
    end
    n_cmp++;
    if (status !== 3'b010) begin
      n_bad++;
      $display("FAIL b2b_done2: got st=%b want 010", status);
    end
    req_valid = 1'b0;
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (status !== 3'b100) begin
      n_bad++;
      $display("FAIL b2b_idle: got st=%b want 100", status);
    end
  endtask

`ifdef GS_SEQ_ABORT_EN
  task automatic test_abort();
    logic seen;
    accept(2'b00);
    repeat (3) step();
    n_cmp++;
    if ({busy, sched} !== {1'b1, div_tab[3]}) begin
      n_bad++;
      $display("FAIL abort_c3: got busy=%b sch=%b want busy=1 sch=%b", busy, sched, div_tab[3]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({status, sched} !== {3'b100, 8'h00}) begin
      n_bad++;
      $display("FAIL abort_idle: got st=%b sch=%b want st=100 sch=00000000", status, sched);
    end
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (resp_valid) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done: got resp_valid_seen=%b want 0", seen);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {sA, sB, enableN, enableD, enableK, enableQD} per RUN cycle
    div_tab  = '{8'b00001000, 8'b00010110, 8'b01101000, 8'b01110110,
                 8'b01101000, 8'b01110110, 8'b01101000, 8'b01110110,
                 8'b01101000, 8'b01110110, 8'b01101000, 8'b10010111};
    sqrt_tab = '{8'b00001000, 8'b00110100,
                 8'b10100110, 8'b01101000, 8'b01110100,
                 8'b10100110, 8'b01101000, 8'b01110100,
                 8'b10100110, 8'b01101000, 8'b01110100,
                 8'b10100110, 8'b01101000, 8'b01110100,
                 8'b01101000};
    test_reset();
    test_divide();
    test_sqrt();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef GS_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/goldschmidt_seq.md
GOLDSCHMIDT_SEQ -- requirements
Module: goldschmidt_seq

Interface
REQ-001 SHALL have parameter DIV_LEN, default 12, meaning the number of division schedule cycles, legal range 4..16.
REQ-002 SHALL have parameter SQRT_ITERS, default 4, meaning the number of square-root iterations of 3 cycles each, legal range 1..4.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, the requester offers an operation.
REQ-006 SHALL have port req_op, input, 2, the operation code: 00 divide, any nonzero value square root.
REQ-007 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port resp_valid, output, 1, a result is held in the datapath N register.
REQ-009 SHALL have port resp_ready, input, 1, the consumer takes the result.
REQ-010 SHALL have port op, output, 2, the latched operation code driven to the datapath.
REQ-011 SHALL have ports sA and sB, output, 2 each, the datapath operand mux selects.
REQ-012 SHALL have ports enableN, enableD, enableK and enableQD, output, 1 each, the datapath register enables.
REQ-013 SHALL have port busy, output, 1, high in RUN.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE, latch req_op into op and clear the cycle counter c to 0 when req_valid and req_ready are both high, then go to RUN.
REQ-016 SHALL, for divide in RUN with last=DIV_LEN-1 and m=(2<=c<last):
- sA={c==last, m}
- sB={m, c[0]}
- enableN=~c[0]
- enableD=enableK=c[0]
- enableQD=(c==last)
REQ-017 SHALL, for square root in RUN, drive this schedule (enables given as N,D,K,QD):
- c=0: sA=00, sB=00, enables 1000.
- c=1: sA=00, sB=11, enables 0100.
- Iteration step t=(c-2) mod 3:
  - t=0: sA=10, sB=10, enables 0110.
  - t=1: sA=01, sB=10, enables 1000.
  - t=2: sA=01, sB=11, enables 0100.
- Final cycle c=2+3*SQRT_ITERS: sA=01, sB=10, enables 1000.
REQ-018 SHALL go from RUN to DONE after the last schedule cycle, giving 12 cycles for divide and 15 cycles for square root at the defaults.
REQ-019 SHALL increment c by 1 every RUN cycle, with no wrap inside an operation.
REQ-020 SHALL, in IDLE and DONE, drive sA=00, sB=00 and all four enables 0.
REQ-021 SHALL assert resp_valid in DONE and hold it until resp_ready is high, then go to IDLE.
REQ-022 SHALL keep req_ready low in DONE, so a new request is accepted no earlier than the cycle after the handshake.
REQ-023 SHALL keep op stable from acceptance through the DONE handshake.
REQ-024 SHALL make all outputs a function of registered state only.

Reset
REQ-025 SHALL, on reset, force state=IDLE, c=0 and op=00.
REQ-026 SHALL, on reset, force resp_valid=0, busy=0 and req_ready=1, with all enables 0.
REQ-027 SHALL, on reset in mid-operation, abandon the operation with no resp_valid pulse.

Configuration
REQ-028 SHALL, with GS_SEQ_ABORT_EN defined, add input abort (1 bit).
REQ-029 SHALL, with GS_SEQ_ABORT_EN defined and abort high, go from RUN or DONE to IDLE at the next edge with enables 0 in that cycle, and abort SHALL take priority over resp_ready.
REQ-030 SHALL, without GS_SEQ_ABORT_EN, have no abort port and run every accepted operation to completion.

Structure
REQ-031 SHALL place the state enum, the op encodings (OP_DIV=00) and the sA/sB select constants in package goldschmidt_pkg.
REQ-032 SHALL contain one combinational sub-module gs_schedule, mapping (op, c, state) to sA, sB and the enables.

Verification
REQ-033 SHALL cover a divide at defaults: accept op=00, then 12 RUN cycles with enableQD=1 only at c=11, then resp_valid=1.
REQ-034 SHALL cover a square root at defaults: accept op=01, then 15 RUN cycles whose sA/sB/enable sequence matches REQ-017 exactly, then DONE.
REQ-035 SHALL cover backpressure: resp_ready held low 5 cycles, so resp_valid stays 1, enables stay 0 and req_ready stays 0, then IDLE one cycle after resp_ready.
REQ-036 SHALL cover reset asserted at RUN c=6: outputs go to reset values immediately and no resp_valid pulse follows.
REQ-037 SHALL cover back-to-back operations: req_valid held high with op=00 then 10, giving two complete operations separated by exactly one IDLE cycle.
REQ-038 SHALL cover abort with GS_SEQ_ABORT_EN defined: abort at c=3 gives IDLE next cycle with no DONE.
